// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer for multi-cycle FPU ops: counts op latency, stalls IF/ID on busy/RAW/WAW
// hazards against the in-flight destination, and pulses writeback when the result is ready.
module fpu_issue_ctrl #(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 4,
  parameter int unsigned LAT_DIV  = 16,
  parameter int unsigned LAT_MISC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       IssueValid,
  input  logic       IssueFPU,
  input  logic [0:2] FPUOp,
  input  logic [0:4] DestReg,
  input  logic       DestFP,
  input  logic       DestWE,
  input  logic [0:4] Src1Reg,
  input  logic       Src1FP,
  input  logic [0:4] Src2Reg,
  input  logic       Src2FP,
  input  logic       Flush,
  output logic       Stall,
  output logic       FPUStart,
  output logic       FPUBusy,
  output logic       WBValid,
  output logic [0:4] WBReg,
  output logic       WBFP
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [0:4] pend_reg_q, pend_reg_d;
  logic       pend_fp_q, pend_fp_d;
  logic       pend_we_q, pend_we_d;

  logic [4:0] lat;
  logic       pend_live, raw_haz, waw_haz, busy_haz, accept;

  always_comb begin
    lat = 5'(LAT_MISC);
    case (FPUOp)
      3'b000, 3'b001, 3'b010, 3'b011: lat = 5'(LAT_ADD);
      3'b100:                         lat = 5'(LAT_MUL);
      3'b101:                         lat = 5'(LAT_DIV);
      default:                        lat = 5'(LAT_MISC);
    endcase
  end

  // GPR R0 is hardwired zero, so a pending write to it can never create a dependency.
  assign pend_live = (state_q == BUSY) & pend_we_q & ~((pend_reg_q == 5'd0) & ~pend_fp_q);
  assign raw_haz   = pend_live & (((Src1Reg == pend_reg_q) & (Src1FP == pend_fp_q)) |
                                  ((Src2Reg == pend_reg_q) & (Src2FP == pend_fp_q)));
  assign waw_haz   = pend_live & DestWE & (DestReg == pend_reg_q) & (DestFP == pend_fp_q);
  assign busy_haz  = IssueFPU & (state_q == BUSY);
  assign Stall     = IssueValid & ~Flush & (busy_haz | raw_haz | waw_haz);
  assign accept    = IssueValid & IssueFPU & ~Flush & ~Stall & (state_q != BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      pend_reg_q <= 5'd0;
      pend_fp_q  <= 1'b0;
      pend_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_reg_q <= pend_reg_d;
      pend_fp_q  <= pend_fp_d;
      pend_we_q  <= pend_we_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_reg_d = pend_reg_q;
    pend_fp_d  = pend_fp_q;
    pend_we_d  = pend_we_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d    = (lat == 5'd1) ? DONE : BUSY;
          cnt_d      = lat - 5'd1;
          pend_reg_d = DestReg;
          pend_fp_d  = DestFP;
          pend_we_d  = DestWE;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    FPUStart = accept;
    FPUBusy  = (state_q == BUSY) | (state_q == DONE);
    WBValid  = (state_q == DONE) & pend_we_q;
    WBReg    = (state_q == DONE) ? pend_reg_q : 5'd0;
    WBFP     = (state_q == DONE) & pend_fp_q;
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed plus randomized bench for fpu_issue_ctrl against a time-based model of the
// in-flight op (issue cycle + latency), checked with immediate assertions.
module tb_fpu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       IssueValid, IssueFPU, DestFP, DestWE, Src1FP, Src2FP, Flush;
  logic [0:2] FPUOp;
  logic [0:4] DestReg, Src1Reg, Src2Reg;
  logic       Stall, FPUStart, FPUBusy, WBValid, WBFP;
  logic [0:4] WBReg;

  always #5 clk = ~clk;

  fpu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .IssueValid(IssueValid), .IssueFPU(IssueFPU), .FPUOp(FPUOp),
    .DestReg(DestReg), .DestFP(DestFP), .DestWE(DestWE), .Src1Reg(Src1Reg), .Src1FP(Src1FP),
    .Src2Reg(Src2Reg), .Src2FP(Src2FP), .Flush(Flush), .Stall(Stall), .FPUStart(FPUStart),
    .FPUBusy(FPUBusy), .WBValid(WBValid), .WBReg(WBReg), .WBFP(WBFP)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  bit op_v = 0;
  int op_issue, op_lat, op_reg;
  bit op_fp, op_we;
  int stall_cnt, start_cyc, wb_cyc, wb_cnt, t0;

  function automatic int lat_of(input int op);
    if (op < 4) return 2;
    if (op == 4) return 4;
    if (op == 5) return 16;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, t);
    end
  endtask

  // One pipeline cycle: drive at posedge+1, check at the falling edge, advance the model.
  task automatic cyc(input bit v, input bit fpu, input int op, input int dr, input bit dfp,
                     input bit dwe, input int s1, input bit s1fp, input int s2, input bit s2fp,
                     input bit fl);
    bit in_busy, done, live, raw, waw, es, acc;
    IssueValid = v;  IssueFPU = fpu;  FPUOp = 3'(op);
    DestReg = 5'(dr); DestFP = dfp; DestWE = dwe;
    Src1Reg = 5'(s1); Src1FP = s1fp; Src2Reg = 5'(s2); Src2FP = s2fp; Flush = fl;
    #4;
    if (op_v && t > op_issue + op_lat) op_v = 0;
    in_busy = op_v && t > op_issue && t < op_issue + op_lat;
    done    = op_v && t == op_issue + op_lat;
    live    = in_busy && op_we && !(op_reg == 0 && !op_fp);
    raw     = live && ((s1 == op_reg && s1fp == op_fp) || (s2 == op_reg && s2fp == op_fp));
    waw     = live && dwe && dr == op_reg && dfp == op_fp;
    es      = v && !fl && ((fpu && in_busy) || raw || waw);
    acc     = v && fpu && !fl && !es;
    chk("stall",    32'(Stall),    32'(es));
    chk("fpustart", 32'(FPUStart), 32'(acc));
    chk("fpubusy",  32'(FPUBusy),  32'(in_busy || done));
    chk("wbvalid",  32'(WBValid),  32'(done && op_we));
    chk("wbreg",    32'(WBReg),    done ? 32'(op_reg) : 32'd0);
    chk("wbfp",     32'(WBFP),     32'(done && op_fp));
    if (Stall === 1'b1) stall_cnt++;
    if (FPUStart === 1'b1) start_cyc = t;
    if (WBValid === 1'b1) begin wb_cyc = t; wb_cnt++; end
    @(posedge clk); #1;
    if (acc) begin
      op_v = 1; op_issue = t; op_lat = lat_of(op);
      op_reg = dr; op_fp = dfp; op_we = dwe;
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(Stall), 32'd0);
    chk({tag, "_start"}, 32'(FPUStart), 32'd0);
    chk({tag, "_busy"},  32'(FPUBusy), 32'd0);
    chk({tag, "_wbv"},   32'(WBValid), 32'd0);
    chk({tag, "_wbreg"}, 32'(WBReg), 32'd0);
    chk({tag, "_wbfp"},  32'(WBFP), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    IssueValid = 0; IssueFPU = 0; FPUOp = '0; DestReg = '0; DestFP = 0; DestWE = 0;
    Src1Reg = '0; Src1FP = 0; Src2Reg = '0; Src2FP = 0; Flush = 0;
    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: MUL to F3, writeback 4 cycles after start
    t0 = t; wb_cyc = -1;
    cyc(1, 1, 4, 3, 1, 1, 10, 1, 11, 1, 0);
    idle(6);
    chk("t1_wb_latency", 32'(wb_cyc - t0), 32'd4);

    // 2: DIV to F5, then ADDF reading F5 held until accepted
    t0 = t; stall_cnt = 0; start_cyc = -1;
    cyc(1, 1, 5, 5, 1, 1, 1, 1, 2, 1, 0);
    start_cyc = -1;
    for (int k = 0; k < 40 && start_cyc < 0; k++) cyc(1, 1, 0, 6, 1, 1, 5, 1, 7, 1, 0);
    chk("t2_stall_cycles", 32'(stall_cnt), 32'd15);
    chk("t2_accept_cycle", 32'(start_cyc - t0), 32'd16);
    idle(4);

    // 3: ADD then a held MUL issues in the DONE cycle
    t0 = t; wb_cnt = 0;
    cyc(1, 1, 0, 1, 1, 1, 12, 1, 13, 1, 0);
    cyc(1, 1, 4, 2, 1, 1, 14, 1, 15, 1, 0);
    cyc(1, 1, 4, 2, 1, 1, 14, 1, 15, 1, 0);
    chk("t3_second_start", 32'(start_cyc - t0), 32'd2);
    idle(6);
    chk("t3_wb_count", 32'(wb_cnt), 32'd2);

    // 4: MUL to F0; integer op on GPR R0 must not stall
    cyc(1, 1, 4, 0, 1, 1, 20, 1, 21, 1, 0);
    stall_cnt = 0;
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("t4_no_false_stall", 32'(stall_cnt), 32'd0);
    cyc(1, 0, 0, 4, 0, 1, 0, 1, 3, 0, 0);
    idle(4);

    // 5: flushed issue is squashed; flush during BUSY keeps the writeback
    start_cyc = -1;
    cyc(1, 1, 4, 8, 1, 1, 1, 1, 2, 1, 1);
    chk("t5_flush_no_start", 32'(start_cyc), 32'hFFFF_FFFF);
    t0 = t; wb_cyc = -1;
    cyc(1, 1, 4, 7, 1, 1, 1, 1, 2, 1, 0);
    cyc(1, 1, 0, 7, 1, 1, 7, 1, 7, 1, 1);
    idle(5);
    chk("t5_wb_after_flush", 32'(wb_cyc - t0), 32'd4);

    // 6: asynchronous reset while a DIV counts down
    cyc(1, 1, 5, 9, 1, 1, 1, 1, 2, 1, 0);
    idle(8);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    op_v = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    t++;
    wb_cnt = 0;
    idle(20);
    chk("t6_no_wb_after_reset", 32'(wb_cnt), 32'd0);

    // Random traffic with a small register pool to provoke hazards
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
          $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3), $urandom_range(0, 1) == 1,
          $urandom_range(0, 3), $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
